multicycle_exec_core: RTL and testbench
=======================================

MULTICYCLE_EXEC_CORE -- requirements
Module: multicycle_exec_core

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (power of two, 32 or 64).
REQ-002 SHALL have parameter NREGS, default 32, architectural register count (power of two, 2..32).
REQ-003 SHALL have parameter PC_RESET, default 0, PC value after reset.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, operation offered.
REQ-007 SHALL have port req_ready, output, 1, core can accept an operation.
REQ-008 SHALL have ports rs1_addr and rs2_addr, input, $clog2(NREGS) each, source register indices.
REQ-009 SHALL have port rd_addr, input, $clog2(NREGS), destination index.
REQ-010 SHALL have ports imm (input, XLEN), use_imm (input, 1, operand2 = imm) and is_branch (input, 1, conditional PC-relative op).
REQ-011 SHALL have port alu_op, input, 4, operation code.
REQ-012 SHALL have ports pc_in (input, XLEN) and pc_load (input, 1, load PC from pc_in).
REQ-013 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_result (output, XLEN) and pc_out (output, XLEN, current PC).

Function
REQ-014 SHALL sequence through states IDLE -> READ -> EXEC -> WB -> IDLE.
REQ-015 SHALL drive req_ready = 1 only in IDLE with pc_load low; accept on req_valid && req_ready; all request fields captured that cycle.
REQ-016 SHALL, in READ, latch rs1/rs2 register contents; x0 always reads 0.
REQ-017 SHALL, in EXEC, compute the ALU result into rsp_result from rs1 and (use_imm ? imm : rs2).
REQ-018 SHALL support alu_op codes 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU; codes 10..15 yield 0.
REQ-019 SHALL use shift amount = low $clog2(XLEN) bits of operand2; ADD/SUB wrap modulo 2^XLEN.
REQ-020 SHALL assert rsp_valid in WB, hold rsp_result stable, and stay in WB until rsp_ready; rsp_valid rises exactly 3 cycles after the accept edge.
REQ-021 SHALL, at the WB handshake cycle, write rsp_result to rd when is_branch = 0 and rd_addr != 0; writes to x0 are discarded.
REQ-022 SHALL, at the WB handshake cycle, set PC = PC + imm when is_branch = 1 and ALU result != 0, else PC = PC + 4 (modulo 2^XLEN).
REQ-023 SHALL, in IDLE, load PC from pc_in on pc_load; pc_load outside IDLE is ignored.
REQ-024 SHALL, when rd of one op equals rs1/rs2 of the next, deliver the written value (no forwarding needed; write precedes next READ).

Reset
REQ-025 SHALL on reset asynchronously force state IDLE, PC = PC_RESET, rsp_valid = 0, rsp_result = 0, all registers = 0.
REQ-026 SHALL, on reset mid-operation, abandon the op with no register write and no PC update.
REQ-027 SHALL drive req_ready = 1 in the first cycle after reset deasserts.

Structure
REQ-028 SHALL take alu_op encodings (enum) and the FSM state enum from shared package riscv_pkg.
REQ-029 SHALL instantiate one sub-module alu_param (combinational, parameter XLEN) for REQ-018/019.

Verification
REQ-030 Reset, write x5 = 7 via ADD x5,x0,imm 7 (use_imm) -> rsp_valid 3 cycles after accept, rsp_result 7, pc_out 4.
REQ-031 SUB x6,x5,x5 then SLTU with rs1 = 0, imm = 0xFFFF_FFFF -> results 0 and 1; SRA of 0x8000_0000 by 31 -> 0xFFFF_FFFF.
REQ-032 ADD x0,x0,imm 9 -> rsp_result 9, subsequent read of x0 returns 0.
REQ-033 Branch with ALU result nonzero, imm = -8, PC = 0x100 -> PC 0xF8; ALU result zero -> PC 0x104; no register written.
REQ-034 rsp_ready held low 5 cycles in WB -> rsp_valid and rsp_result stable, PC unchanged until handshake; pc_load during EXEC ignored.
REQ-035 Assert reset in EXEC of a write to x3 -> x3 stays 0, PC = PC_RESET, req_ready = 1 the cycle after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle execute core: ALU operation codes and
// the control FSM states.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_param.sv
// Combinational XLEN-wide ALU; unassigned opcodes produce zero and shifts use
// only the low log2(XLEN) bits of the second operand.
module alu_param
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt_s;
  assign shamt_s = b[SHW-1:0];

  // Operation select
  always_comb begin
    y = '0;
    case (alu_op_e'(op))
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << shamt_s;
      ALU_SRL:  y = a >> shamt_s;
      ALU_SRA:  y = $signed(a) >>> shamt_s;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_exec_core.sv
// Multicycle execute core: one operation at a time through IDLE/READ/EXEC/WB,
// with a local register file (x0 hardwired to zero) and PC sequencing.
module multicycle_exec_core
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  input  logic [XLEN-1:0]          imm,
  input  logic                     use_imm,
  input  logic                     is_branch,
  input  logic [3:0]               alu_op,
  input  logic [XLEN-1:0]          pc_in,
  input  logic                     pc_load,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_result,
  output logic [XLEN-1:0]          pc_out
);

  localparam int              AW     = $clog2(NREGS);
  localparam logic [XLEN-1:0] PC_INC = XLEN'(32'd4);

  state_e          state_r, state_nx_s;
  logic [AW-1:0]   rs1_idx_r, rs2_idx_r, rd_idx_r;
  logic [XLEN-1:0] imm_r;
  logic            use_imm_r, is_branch_r;
  logic [3:0]      alu_op_r;
  logic [XLEN-1:0] rs1_val_r, rs2_val_r;
  logic [XLEN-1:0] rsp_result_r;
  logic            rsp_valid_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] regs_r [NREGS];
  logic [XLEN-1:0] alu_y_s;
  logic            accept_s, wb_done_s;

  assign req_ready  = (state_r == ST_IDLE) && !pc_load;
  assign accept_s   = req_valid && req_ready;
  assign wb_done_s  = (state_r == ST_WB) && rsp_ready;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign pc_out     = pc_r;

  alu_param #(.XLEN(XLEN)) u_alu (
    .op (alu_op_r),
    .a  (rs1_val_r),
    .b  (use_imm_r ? imm_r : rs2_val_r),
    .y  (alu_y_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nx_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = ST_READ;
        else          state_nx_s = ST_IDLE;
      end
      ST_READ: state_nx_s = ST_EXEC;
      ST_EXEC: state_nx_s = ST_WB;
      ST_WB: begin
        if (rsp_ready) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_WB;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Capture request fields on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_idx_r   <= '0;
      rs2_idx_r   <= '0;
      rd_idx_r    <= '0;
      imm_r       <= '0;
      use_imm_r   <= 1'b0;
      is_branch_r <= 1'b0;
      alu_op_r    <= 4'd0;
    end else if (accept_s) begin
      rs1_idx_r   <= rs1_addr;
      rs2_idx_r   <= rs2_addr;
      rd_idx_r    <= rd_addr;
      imm_r       <= imm;
      use_imm_r   <= use_imm;
      is_branch_r <= is_branch;
      alu_op_r    <= alu_op;
    end
  end

  // Operand fetch in READ; index 0 is forced to zero regardless of storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_val_r <= '0;
      rs2_val_r <= '0;
    end else if (state_r == ST_READ) begin
      rs1_val_r <= (rs1_idx_r == '0) ? '0 : regs_r[rs1_idx_r];
      rs2_val_r <= (rs2_idx_r == '0) ? '0 : regs_r[rs2_idx_r];
    end
  end

  // Result register: loaded in EXEC, held through WB until handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result_r <= '0;
      rsp_valid_r  <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      rsp_result_r <= alu_y_s;
      rsp_valid_r  <= 1'b1;
    end else if (wb_done_s) begin
      rsp_valid_r  <= 1'b0;
    end
  end

  // Register file write-back; branches and x0 targets leave the file untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= '0;
    end else if (wb_done_s && !is_branch_r && (rd_idx_r != '0)) begin
      regs_r[rd_idx_r] <= rsp_result_r;
    end
  end

  // Program counter: explicit load only while idle, otherwise advance at WB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= PC_RESET;
    end else if ((state_r == ST_IDLE) && pc_load) begin
      pc_r <= pc_in;
    end else if (wb_done_s) begin
      if (is_branch_r && (rsp_result_r != '0)) pc_r <= pc_r + imm_r;
      else                                     pc_r <= pc_r + PC_INC;
    end
  end

endmodule

// File: tb/tb_multicycle_exec_core.sv
// Scoreboard-based bench for multicycle_exec_core: expected results are queued
// as each operation is issued and compared when the response appears.
module tb_multicycle_exec_core;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] imm;
  logic        use_imm, is_branch;
  logic [3:0]  alu_op;
  logic [31:0] pc_in;
  logic        pc_load;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result, pc_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_exec_core #(.XLEN(32), .NREGS(32), .PC_RESET(32'h0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .imm(imm),
    .use_imm(use_imm), .is_branch(is_branch), .alu_op(alu_op), .pc_in(pc_in),
    .pc_load(pc_load), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .pc_out(pc_out)
  );

  // Issue one op and wait (bounded) for rsp_valid; leaves the DUT in WB.
  task automatic do_op(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [31:0] iv, input logic ui,
                       input logic br, output logic [31:0] res, output int lat);
    int n;
    @(negedge clk);
    alu_op = op; rd_addr = rd; rs1_addr = r1; rs2_addr = r2;
    imm = iv; use_imm = ui; is_branch = br; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    res = rsp_result;
  endtask

  task automatic finish_wb();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic load_pc(input logic [31:0] v);
    @(negedge clk);
    pc_load = 1'b1; pc_in = v;
    @(posedge clk); #1;
    pc_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; pc_load = 1'b0; pc_in = '0;
    rs1_addr = '0; rs2_addr = '0; rd_addr = '0; imm = '0;
    use_imm = 1'b0; is_branch = 1'b0; alu_op = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", rsp_result); end
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", pc_out); end
  endtask

  task automatic test_add();
    logic [31:0] r, e; int lat;
    exp_q.push_back(32'd7);
    do_op(ALU_ADD, 5'd5, 5'd0, 5'd0, 32'd7, 1'b1, 1'b0, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d expected 3", lat); end
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL add_result: got %h expected %h", r, e); end
    finish_wb();
    n_checks++; if (pc_out !== 32'd4) begin n_fail++; $display("FAIL add_pc: got %h expected 4", pc_out); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_valid_drop: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_alu_ops();
    logic [31:0] r, e; int lat;
    logic [3:0]  op_t [8] = '{ALU_SUB, ALU_SLTU, ALU_ADD, ALU_SRA, ALU_SLT, ALU_ADD, 4'd12, ALU_SLL};
    logic [4:0]  rd_t [8] = '{5'd6, 5'd0, 5'd7, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [4:0]  r1_t [8] = '{5'd5, 5'd0, 5'd0, 5'd7, 5'd7, 5'd7, 5'd5, 5'd5};
    logic [4:0]  r2_t [8] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0};
    logic [31:0] im_t [8] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd31, 32'd1,
                              32'h8000_0000, 32'h0, 32'h0000_0022};
    logic        ui_t [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] ex_t [8] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1,
                              32'h0, 32'h0, 32'h0000_001C};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(ex_t[i]);
      do_op(op_t[i], rd_t[i], r1_t[i], r2_t[i], im_t[i], ui_t[i], 1'b0, r, lat);
      e = exp_q.pop_front();
      n_checks++; if (r !== e) begin n_fail++; $display("FAIL alu_op%0d: got %h expected %h", i, r, e); end
      finish_wb();
    end
  endtask

  task automatic test_x0_and_hazard();
    logic [31:0] r, e; int lat;
    logic [3:0]  op_t [5] = '{ALU_ADD, ALU_OR, ALU_ADD, ALU_ADD, ALU_ADD};
    logic [4:0]  rd_t [5] = '{5'd0, 5'd0, 5'd9, 5'd10, 5'd0};
    logic [4:0]  r1_t [5] = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd10};
    logic [31:0] im_t [5] = '{32'd9, 32'h0, 32'h55, 32'd1, 32'h0};
    logic        ui_t [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] ex_t [5] = '{32'd9, 32'h0, 32'h55, 32'h56, 32'h56};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ex_t[i]);
      do_op(op_t[i], rd_t[i], r1_t[i], 5'd0, im_t[i], ui_t[i], 1'b0, r, lat);
      e = exp_q.pop_front();
      n_checks++; if (r !== e) begin n_fail++; $display("FAIL x0_hazard%0d: got %h expected %h", i, r, e); end
      finish_wb();
    end
  endtask

  task automatic test_branch();
    logic [31:0] r, e; int lat;
    load_pc(32'h100);
    n_checks++; if (pc_out !== 32'h100) begin n_fail++; $display("FAIL pc_load: got %h expected 00000100", pc_out); end
    exp_q.push_back(32'hFFFF_FFF8);
    do_op(ALU_ADD, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFF8, 1'b1, 1'b1, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL br_taken_result: got %h expected %h", r, e); end
    finish_wb();
    n_checks++; if (pc_out !== 32'h0000_00F8) begin n_fail++; $display("FAIL br_taken_pc: got %h expected 000000f8", pc_out); end
    load_pc(32'h100);
    exp_q.push_back(32'h0);
    do_op(ALU_SUB, 5'd5, 5'd5, 5'd5, 32'hFFFF_FFF8, 1'b0, 1'b1, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL br_not_taken_result: got %h expected %h", r, e); end
    finish_wb();
    n_checks++; if (pc_out !== 32'h104) begin n_fail++; $display("FAIL br_not_taken_pc: got %h expected 00000104", pc_out); end
    exp_q.push_back(32'd7);
    do_op(ALU_ADD, 5'd0, 5'd5, 5'd0, 32'h0, 1'b1, 1'b0, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL br_no_write: got %h expected %h", r, e); end
    finish_wb();
    n_checks++; if (pc_out !== 32'h108) begin n_fail++; $display("FAIL br_seq_pc: got %h expected 00000108", pc_out); end
  endtask

  task automatic test_stall();
    logic [31:0] r, e; int n;
    exp_q.push_back(32'h1234);
    @(negedge clk);
    alu_op = ALU_ADD; rd_addr = 5'd11; rs1_addr = 5'd0; rs2_addr = 5'd0;
    imm = 32'h1234; use_imm = 1'b1; is_branch = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    pc_load = 1'b1; pc_in = 32'hDEAD_0000;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    pc_load = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_wait: rsp_valid never rose within budget"); end
    r = rsp_result;
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL stall_result: got %h expected %h", r, e); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== e || pc_out !== 32'h108) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got valid=%b result=%h pc=%h expected 1 %h 00000108",
                 i, rsp_valid, rsp_result, pc_out, e);
      end
    end
    finish_wb();
    n_checks++; if (pc_out !== 32'h10C) begin n_fail++; $display("FAIL stall_pc: got %h expected 0000010c", pc_out); end
    exp_q.push_back(32'h1234);
    do_op(ALU_ADD, 5'd0, 5'd11, 5'd0, 32'h0, 1'b1, 1'b0, r, n);
    e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL stall_readback: got %h expected %h", r, e); end
    finish_wb();
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r, e; int lat;
    @(negedge clk);
    alu_op = ALU_ADD; rd_addr = 5'd3; rs1_addr = 5'd0; rs2_addr = 5'd0;
    imm = 32'h77; use_imm = 1'b1; is_branch = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", req_ready); end
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_mid_pc: got %h expected 0", pc_out); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", rsp_valid); end
    exp_q.push_back(32'h0);
    do_op(ALU_ADD, 5'd0, 5'd3, 5'd0, 32'h0, 1'b1, 1'b0, r, lat);
    e = exp_q.pop_front();
    n_checks++; if (r !== e) begin n_fail++; $display("FAIL rst_mid_x3: got %h expected %h", r, e); end
    finish_wb();
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_x0_and_hazard();
    test_branch();
    test_stall();
    test_reset_mid_op();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
